// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port
// between NUM_REQ valid/ready/last producers. A grant is held for a whole
// packet or MAX_BURST words, whichever ends first, and FIFO full stalls
// the granted producer combinationally.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ-1:0]       i_req_last,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_wr_en,
    output logic [WIDTH-1:0]         o_fifo_data,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant_n;
    logic               busy_n;
    logic [PW-1:0]      rr_ptr, rr_n;
    logic [PW-1:0]      gidx, gidx_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [PW-1:0]      win;
    logic               win_found;
    logic               xfer;
    int unsigned        scan_idx;
    logic [WIDTH-1:0]   data_word [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign data_word[k] = i_req_data[k*WIDTH +: WIDTH];
    end

    // Round-robin scan: first valid producer starting at rr_ptr, wrapping.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_found && i_req_valid[PW'(scan_idx)]) begin
                win       = PW'(scan_idx);
                win_found = 1'b1;
            end
        end
    end

    // Next-state, grant bookkeeping and write-port outputs.
    always_comb begin
        state_n      = state;
        grant_n      = o_grant;
        busy_n       = o_busy;
        rr_n         = rr_ptr;
        cnt_n        = cnt;
        gidx_n       = gidx;
        xfer         = 1'b0;
        o_req_ready  = '0;
        o_fifo_wr_en = 1'b0;
        o_fifo_data  = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = LOCKED;
                    grant_n = NUM_REQ'(1) << win;
                    busy_n  = 1'b1;
                    gidx_n  = win;
                    cnt_n   = '0;
                end
            end
            LOCKED: begin
                o_req_ready[gidx] = ~i_fifo_full;
                xfer              = i_req_valid[gidx] & ~i_fifo_full;
                o_fifo_wr_en      = xfer;
                o_fifo_data       = data_word[gidx];
                if (xfer) begin
                    cnt_n = cnt + 1'b1;
                    if (i_req_last[gidx] || cnt == CW'(MAX_BURST - 1)) begin
                        state_n = IDLE;
                        grant_n = '0;
                        busy_n  = 1'b0;
                        cnt_n   = '0;
                        rr_n    = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Reset gates the write port immediately, not just at the next edge.
        if (i_rst) begin
            o_req_ready  = '0;
            o_fifo_wr_en = 1'b0;
            o_fifo_data  = '0;
        end
    end

    // State, grant, priority pointer and burst counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_grant <= '0;
            o_busy  <= 1'b0;
            rr_ptr  <= '0;
            cnt     <= '0;
            gidx    <= '0;
        end else begin
            state   <= state_n;
            o_grant <= grant_n;
            o_busy  <= busy_n;
            rr_ptr  <= rr_n;
            cnt     <= cnt_n;
            gidx    <= gidx_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a
// randomized run checked against a cycle-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   valid, last;
    logic [N*W-1:0] data;
    logic           full;
    logic [N-1:0]   ready;
    logic           wr_en;
    logic [W-1:0]   fdata;
    logic [N-1:0]   grant;
    logic           busy;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (valid),
        .i_req_last  (last),
        .i_req_data  (data),
        .o_req_ready (ready),
        .i_fifo_full (full),
        .o_fifo_wr_en(wr_en),
        .o_fifo_data (fdata),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = '0;
        last  = '0;
        data  = '0;
        full  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_word(input int k, input logic [W-1:0] w);
        data[k*W +: W] = w;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = '1; last = '0; full = 1'b0; data = '1;
        #1;
        checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got=%b exp=0000", ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
        checks++; if (fdata !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", fdata); end
        tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst = 1'b0; valid = '0;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || wr_en !== 1'b0)
            begin errors++; $display("FAIL post_rst_idle got grant=%b busy=%b wr=%b exp 0000/0/0", grant, busy, wr_en); end
        tick();
    endtask

    task automatic test_single_producer();
        do_reset();
        valid[2] = 1'b1; set_word(2, 8'hA0);
        #1;
        checks++; if (grant !== 4'b0000 || ready !== 4'b0000 || wr_en !== 1'b0)
            begin errors++; $display("FAIL sp_idle got grant=%b ready=%b wr=%b exp 0000/0000/0", grant, ready, wr_en); end
        tick();
        checks++; if (grant !== 4'b0100 || busy !== 1'b1)
            begin errors++; $display("FAIL sp_grant got grant=%b busy=%b exp 0100/1", grant, busy); end
        for (int n = 0; n < 3; n++) begin
            last[2] = (n == 2);
            set_word(2, 8'(8'hA0 + n));
            #1;
            checks++; if (wr_en !== 1'b1 || fdata !== 8'(8'hA0 + n) || ready !== 4'b0100)
                begin errors++; $display("FAIL sp_word%0d got wr=%b data=%h ready=%b exp 1/%h/0100", n, wr_en, fdata, ready, 8'(8'hA0 + n)); end
            tick();
        end
        valid = '0; last = '0;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0)
            begin errors++; $display("FAIL sp_release got grant=%b busy=%b exp 0000/0", grant, busy); end
        valid = 4'b1001;
        tick();
        checks++; if (grant !== 4'b1000)
            begin errors++; $display("FAIL sp_next_ptr got=%b exp=1000", grant); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        do_reset();
        valid = '1; last = '0;
        for (int k = 0; k < N; k++) set_word(k, 8'(16 * (k + 1)));
        #1;
        for (int j = 0; j < 5; j++) begin
            checks++; if (grant !== 4'b0000 || wr_en !== 1'b0)
                begin errors++; $display("FAIL rr_idle%0d got grant=%b wr=%b exp 0000/0", j, grant, wr_en); end
            tick();
            eg = 4'b0001 << (j % N);
            for (int b = 0; b < MB; b++) begin
                checks++; if (grant !== eg || wr_en !== 1'b1 || fdata !== 8'(16 * (j % N + 1)))
                    begin errors++; $display("FAIL rr_g%0d_w%0d got grant=%b wr=%b data=%h exp %b/1/%h", j, b, grant, wr_en, fdata, eg, 8'(16 * (j % N + 1))); end
                tick();
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        valid = 4'b1010; set_word(1, 8'h50); set_word(3, 8'hEE);
        tick();
        checks++; if (grant !== 4'b0010 || wr_en !== 1'b1 || fdata !== 8'h50)
            begin errors++; $display("FAIL fs_first got grant=%b wr=%b data=%h exp 0010/1/50", grant, wr_en, fdata); end
        tick();
        set_word(1, 8'h51); full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (ready !== 4'b0000 || wr_en !== 1'b0 || grant !== 4'b0010)
                begin errors++; $display("FAIL fs_stall%0d got ready=%b wr=%b grant=%b exp 0000/0/0010", s, ready, wr_en, grant); end
            tick();
        end
        full = 1'b0;
        for (int n = 1; n < 4; n++) begin
            set_word(1, 8'(8'h50 + n));
            #1;
            checks++; if (wr_en !== 1'b1 || fdata !== 8'(8'h50 + n) || ready !== 4'b0010)
                begin errors++; $display("FAIL fs_resume%0d got wr=%b data=%h ready=%b exp 1/%h/0010", n, wr_en, fdata, ready, 8'(8'h50 + n)); end
            tick();
        end
        valid = '0;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0)
            begin errors++; $display("FAIL fs_release got grant=%b busy=%b exp 0000/0", grant, busy); end
    endtask

    task automatic test_last_then_other();
        do_reset();
        valid = 4'b1001; last[0] = 1'b1; set_word(0, 8'hC0); set_word(3, 8'hC3);
        tick();
        checks++; if (grant !== 4'b0001 || wr_en !== 1'b1 || fdata !== 8'hC0)
            begin errors++; $display("FAIL lo_p0 got grant=%b wr=%b data=%h exp 0001/1/C0", grant, wr_en, fdata); end
        tick();
        valid[0] = 1'b0; last[0] = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || wr_en !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL lo_gap got grant=%b wr=%b busy=%b exp 0000/0/0", grant, wr_en, busy); end
        tick();
        checks++; if (grant !== 4'b1000 || wr_en !== 1'b1 || fdata !== 8'hC3)
            begin errors++; $display("FAIL lo_p3 got grant=%b wr=%b data=%h exp 1000/1/C3", grant, wr_en, fdata); end
        last[3] = 1'b1;
        tick();
        valid = '0; last = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        valid[1] = 1'b1; last[1] = 1'b1;
        tick();
        tick();
        valid = '0; last = '0;
        valid[2] = 1'b1; set_word(2, 8'hE0);
        tick();
        checks++; if (grant !== 4'b0100 || wr_en !== 1'b1 || fdata !== 8'hE0)
            begin errors++; $display("FAIL rm_w0 got grant=%b wr=%b data=%h exp 0100/1/E0", grant, wr_en, fdata); end
        tick();
        set_word(2, 8'hE1);
        #1;
        checks++; if (wr_en !== 1'b1 || fdata !== 8'hE1)
            begin errors++; $display("FAIL rm_w1 got wr=%b data=%h exp 1/E1", wr_en, fdata); end
        tick();
        set_word(2, 8'hE2); rst = 1'b1;
        #1;
        checks++; if (ready !== 4'b0000 || wr_en !== 1'b0 || fdata !== 8'h00)
            begin errors++; $display("FAIL rm_rst_cycle got ready=%b wr=%b data=%h exp 0000/0/00", ready, wr_en, fdata); end
        tick();
        rst = 1'b0; valid = 4'b1001;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0)
            begin errors++; $display("FAIL rm_after got grant=%b busy=%b exp 0000/0", grant, busy); end
        tick();
        checks++; if (grant !== 4'b0001)
            begin errors++; $display("FAIL rm_ptr0 got=%b exp=0001", grant); end
    endtask

    task automatic test_valid_gap();
        do_reset();
        valid = '1; last = '0;
        for (int k = 0; k < N; k++) set_word(k, 8'(8'h30 + k));
        tick();
        checks++; if (grant !== 4'b0001 || wr_en !== 1'b1 || fdata !== 8'h30)
            begin errors++; $display("FAIL vg_first got grant=%b wr=%b data=%h exp 0001/1/30", grant, wr_en, fdata); end
        tick();
        valid[0] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            #1;
            checks++; if (grant !== 4'b0001 || wr_en !== 1'b0)
                begin errors++; $display("FAIL vg_gap%0d got grant=%b wr=%b exp 0001/0", s, grant, wr_en); end
            tick();
        end
        valid[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (grant !== 4'b0001 || wr_en !== 1'b1)
                begin errors++; $display("FAIL vg_resume%0d got grant=%b wr=%b exp 0001/1", n, grant, wr_en); end
            tick();
        end
        checks++; if (grant !== 4'b0000 || busy !== 1'b0)
            begin errors++; $display("FAIL vg_release got grant=%b busy=%b exp 0000/0", grant, busy); end
        tick();
        checks++; if (grant !== 4'b0010)
            begin errors++; $display("FAIL vg_next got=%b exp=0010", grant); end
    endtask

    // Reference: owner is the producer holding the write port (-1 = none),
    // words counts its transfers in this grant, ptr is the next priority.
    task automatic test_random();
        int           owner, words, ptr, c;
        logic [N-1:0] e_grant, e_ready;
        logic         e_busy, e_wr;
        logic [W-1:0] e_data;
        do_reset();
        owner = -1; words = 0; ptr = 0;
        for (int n = 0; n < 800; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            valid = N'($urandom);
            last  = N'($urandom & $urandom);
            full  = ($urandom_range(0, 3) == 0);
            data  = ($urandom);
            #1;
            e_busy  = (owner >= 0);
            e_grant = e_busy ? (4'b0001 << owner) : 4'b0000;
            e_ready = (!rst && e_busy && !full) ? e_grant : 4'b0000;
            e_wr    = 1'b0;
            e_data  = 8'h00;
            if (!rst && e_busy) begin
                e_wr   = valid[owner] && !full;
                e_data = data[owner*W +: W];
            end
            checks++; if (grant !== e_grant || busy !== e_busy)
                begin errors++; $display("FAIL rnd_grant c%0d got %b/%b exp %b/%b", n, grant, busy, e_grant, e_busy); end
            checks++; if (ready !== e_ready || wr_en !== e_wr)
                begin errors++; $display("FAIL rnd_port c%0d got ready=%b wr=%b exp %b/%b", n, ready, wr_en, e_ready, e_wr); end
            if (e_wr || rst || !e_busy) begin
                checks++; if (fdata !== e_data)
                    begin errors++; $display("FAIL rnd_data c%0d got=%h exp=%h", n, fdata, e_data); end
            end
            tick();
            if (rst) begin
                owner = -1; words = 0; ptr = 0;
            end else if (owner < 0) begin
                for (int i = 0; i < N; i++) begin
                    c = (ptr + i) % N;
                    if (owner < 0 && valid[c]) begin
                        owner = c;
                        words = 0;
                    end
                end
            end else if (e_wr) begin
                words++;
                if (last[owner] || words == MB) begin
                    ptr   = (owner + 1) % N;
                    owner = -1;
                    words = 0;
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid = '0; last = '0; data = '0; full = 1'b0;
        tick();
        test_reset();
        test_single_producer();
        test_round_robin();
        test_full_stall();
        test_last_then_other();
        test_reset_mid_burst();
        test_valid_gap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
